// File: rtl/fir_coeff_ctrl_if.sv
// Coefficient-load handshake bundle: a master streams signed tap words, the
// controller answers with ready while it can take another word.
interface fir_coeff_ctrl_if #(
    parameter int TAP_COEFF_WIDTH = 5
);
    logic                              cfg_valid;
    logic signed [TAP_COEFF_WIDTH-1:0] cfg_data;
    logic                              cfg_last;
    logic                              cfg_ready;

    modport master (
        output cfg_valid,
        output cfg_data,
        output cfg_last,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_data,
        input  cfg_last,
        output cfg_ready
    );
endinterface

// File: rtl/fir_coeff_ctrl.sv
// FIR coefficient controller: loads a full tap set into a shadow bank, gates the
// filter input while the delay line drains, then swaps the set into the active bank.
module fir_coeff_ctrl #(
    parameter int TAP_COEFF_WIDTH = 5,
    parameter int NUM_TAPS        = 50,
    parameter int DRAIN_CYCLES    = NUM_TAPS
) (
    input  logic                                clk,
    input  logic                                rst,
    fir_coeff_ctrl_if.slave                     cfg,
    output logic [TAP_COEFF_WIDTH*NUM_TAPS-1:0] tap_coeffs,
    output logic                                in_gate,
    output logic                                busy,
    output logic                                done,
    output logic                                err
);

    localparam int IDX_W  = $clog2(NUM_TAPS);
    localparam int DCNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);

    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_TAPS - 1);
    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_CYCLES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    logic [1:0]                          r_state;
    logic [IDX_W-1:0]                    r_index;
    logic [DCNT_W-1:0]                   r_drainCnt;
    logic                                r_ready;
    logic                                r_done;
    logic                                r_err;
    logic [TAP_COEFF_WIDTH-1:0]          r_shadow [NUM_TAPS];
    logic [TAP_COEFF_WIDTH*NUM_TAPS-1:0] r_active;

    logic [1:0] w_nextState;
    logic       w_handshake;
    logic       w_abort;

    assign w_handshake = cfg.cfg_valid & r_ready;

    // A set is only well framed when cfg_last lands exactly on the final tap.
    always_comb begin
        w_nextState = r_state;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_handshake) begin
                    if (cfg.cfg_last) w_abort     = 1'b1;
                    else              w_nextState = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_handshake) begin
                    if (r_index == LAST_IDX) begin
                        if (cfg.cfg_last) w_nextState = S_DRAIN;
                        else              w_abort     = 1'b1;
                    end else if (cfg.cfg_last) begin
                        w_abort = 1'b1;
                    end
                end
                if (w_abort) w_nextState = S_IDLE;
            end
            S_DRAIN: begin
                if (r_drainCnt == DRAIN_LAST) w_nextState = S_COMMIT;
            end
            S_COMMIT: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Ready is registered from the next state, so it stays low while reset is
    // held and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_index    <= '0;
            r_drainCnt <= '0;
            r_ready    <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_active   <= '0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            r_state <= w_nextState;
            r_ready <= (w_nextState == S_IDLE) || (w_nextState == S_LOAD);
            r_err   <= w_abort;
            r_done  <= (r_state == S_COMMIT);

            if (w_handshake) begin
                r_shadow[r_index] <= cfg.cfg_data;
            end

            if (w_abort || (w_nextState == S_DRAIN)) begin
                r_index <= '0;
            end else if (w_handshake) begin
                r_index <= r_index + IDX_W'(1);
            end

            if ((r_state == S_DRAIN) && (w_nextState == S_DRAIN)) begin
                r_drainCnt <= r_drainCnt + DCNT_W'(1);
            end else begin
                r_drainCnt <= '0;
            end

            if (r_state == S_COMMIT) begin
                for (int i = 0; i < NUM_TAPS; i++) begin
                    r_active[i*TAP_COEFF_WIDTH +: TAP_COEFF_WIDTH] <= r_shadow[i];
                end
            end
        end
    end

    assign cfg.cfg_ready = r_ready;
    assign tap_coeffs    = r_active;
    assign in_gate       = (r_state == S_DRAIN) || (r_state == S_COMMIT);
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign err           = r_err;

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Directed bench for fir_coeff_ctrl with 4 taps, 4 drain cycles and 5-bit coefficients.
module tb_fir_coeff_ctrl;

    localparam int W     = 5;
    localparam int TAPS  = 4;
    localparam int DRAIN = 4;

    logic            clk;
    logic            rst;
    logic [W*TAPS-1:0] tapCoeffs;
    logic            inGate;
    logic            busy;
    logic            done;
    logic            err;

    int vectorCount = 0;
    int errorCount  = 0;

    logic [W*TAPS-1:0] expSet1;
    logic [W*TAPS-1:0] expSet2;
    logic [W*TAPS-1:0] expSet3;

    fir_coeff_ctrl_if #(.TAP_COEFF_WIDTH(W)) cfgBus ();

    fir_coeff_ctrl #(
        .TAP_COEFF_WIDTH(W),
        .NUM_TAPS(TAPS),
        .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg(cfgBus),
        .tap_coeffs(tapCoeffs),
        .in_gate(inGate),
        .busy(busy),
        .done(done),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Offers one word for exactly one edge; the controller must be ready for it.
    task automatic applyStimulus(input logic [W-1:0] data, input logic last);
        checkOutput("ready_before_word", 32'(cfgBus.cfg_ready), 32'd1);
        cfgBus.cfg_valid = 1'b1;
        cfgBus.cfg_data  = data;
        cfgBus.cfg_last  = last;
        stepCycle();
        cfgBus.cfg_valid = 1'b0;
        cfgBus.cfg_last  = 1'b0;
    endtask

    // Samples k=1.. start right after the last-word edge; done lands at k=6.
    task automatic checkCommit(input logic [W*TAPS-1:0] oldSet, input logic [W*TAPS-1:0] newSet, input logic holdValid);
        for (int k = 1; k <= 7; k++) begin
            checkOutput($sformatf("in_gate_k%0d", k), 32'(inGate), 32'(k <= 5));
            checkOutput($sformatf("busy_k%0d", k), 32'(busy), 32'(k <= 5));
            checkOutput($sformatf("ready_k%0d", k), 32'(cfgBus.cfg_ready), 32'(k >= 6));
            checkOutput($sformatf("done_k%0d", k), 32'(done), 32'(k == 6));
            checkOutput($sformatf("taps_k%0d", k), 32'(tapCoeffs), 32'((k >= 6) ? newSet : oldSet));
            cfgBus.cfg_valid = holdValid && (k < 6);
            cfgBus.cfg_data  = 5'd9;
            stepCycle();
        end
        cfgBus.cfg_valid = 1'b0;
    endtask

    task automatic checkAbort(input logic [W*TAPS-1:0] keptSet);
        for (int k = 1; k <= 3; k++) begin
            checkOutput($sformatf("err_k%0d", k), 32'(err), 32'(k == 1));
            checkOutput($sformatf("abort_in_gate_k%0d", k), 32'(inGate), 32'd0);
            checkOutput($sformatf("abort_busy_k%0d", k), 32'(busy), 32'd0);
            checkOutput($sformatf("abort_taps_k%0d", k), 32'(tapCoeffs), 32'(keptSet));
            stepCycle();
        end
    endtask

    initial begin
        expSet1 = {5'd15, 5'd1, 5'b11110, 5'd3};
        expSet2 = {5'd5, 5'd5, 5'd5, 5'd5};
        expSet3 = {5'd4, 5'd3, 5'd2, 5'd1};

        rst              = 1'b0;
        cfgBus.cfg_valid = 1'b0;
        cfgBus.cfg_data  = '0;
        cfgBus.cfg_last  = 1'b0;
        repeat (3) stepCycle();

        checkOutput("rst_ready", 32'(cfgBus.cfg_ready), 32'd0);
        checkOutput("rst_taps", 32'(tapCoeffs), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_in_gate", 32'(inGate), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);

        rst = 1'b1;
        stepCycle();
        checkOutput("rel_ready", 32'(cfgBus.cfg_ready), 32'd1);
        checkOutput("rel_taps", 32'(tapCoeffs), 32'd0);
        checkOutput("rel_busy", 32'(busy), 32'd0);
        checkOutput("rel_in_gate", 32'(inGate), 32'd0);

        // Back-to-back full set
        applyStimulus(5'd3, 1'b0);
        checkOutput("load_busy", 32'(busy), 32'd1);
        applyStimulus(5'b11110, 1'b0);
        applyStimulus(5'd1, 1'b0);
        applyStimulus(5'd15, 1'b1);
        checkCommit('0, expSet1, 1'b0);

        // cfg_last too early
        applyStimulus(5'd1, 1'b0);
        applyStimulus(5'd2, 1'b1);
        checkAbort(expSet1);

        // Four words with no cfg_last
        applyStimulus(5'd7, 1'b0);
        applyStimulus(5'd7, 1'b0);
        applyStimulus(5'd7, 1'b0);
        checkOutput("nolast_err_before", 32'(err), 32'd0);
        applyStimulus(5'd7, 1'b0);
        checkAbort(expSet1);

        // Valid-gapped load, then valid held through drain and commit
        for (int n = 0; n < TAPS; n++) begin
            applyStimulus(5'd5, n == TAPS - 1);
            if (n < TAPS - 1) begin
                stepCycle();
                checkOutput($sformatf("gap_busy_%0d", n), 32'(busy), 32'd1);
                checkOutput($sformatf("gap_ready_%0d", n), 32'(cfgBus.cfg_ready), 32'd1);
            end
        end
        checkCommit(expSet1, expSet2, 1'b1);

        // Reset in the second drain cycle
        applyStimulus(5'd1, 1'b0);
        applyStimulus(5'd2, 1'b0);
        applyStimulus(5'd3, 1'b0);
        applyStimulus(5'd4, 1'b1);
        checkOutput("pre_rst_in_gate", 32'(inGate), 32'd1);
        stepCycle();
        rst = 1'b0;
        #2;
        checkOutput("async_rst_taps", 32'(tapCoeffs), 32'd0);
        checkOutput("async_rst_in_gate", 32'(inGate), 32'd0);
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        checkOutput("async_rst_ready", 32'(cfgBus.cfg_ready), 32'd0);
        stepCycle();
        rst = 1'b1;
        stepCycle();
        checkOutput("rerel_ready", 32'(cfgBus.cfg_ready), 32'd1);
        applyStimulus(5'd1, 1'b0);
        applyStimulus(5'd2, 1'b0);
        applyStimulus(5'd3, 1'b0);
        applyStimulus(5'd4, 1'b1);
        checkCommit('0, expSet3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, errorCount);
        $finish;
    end

endmodule
